res_station_array: RTL and testbench

Parametrised multi-entry reservation station for the Tomasulo back end. It sits between the instruction queue and one ALU. It buffers up to DEPTH dispatched ops and snoops NUM_CDB common-data-bus ports to wake waiting operands. Each cycle it offers the oldest fully-ready op to the ALU through a valid/ready handshake. It supersedes the single-entry reservation station: more entries, multi-port CDB snoop, same-cycle bypass, flush and out-of-order issue.

---
 rtl/res_station_array.sv | 175 +++++++++++++++++
 tb/tb_res_station_array.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/res_station_array.sv
// Multi-entry reservation station feeding one ALU.
// Entries are kept compacted in age order (slot 0 oldest). Waiting operands
// are woken by snooping NUM_CDB broadcast ports, and the oldest ready entry
// is offered to the ALU through a valid/ready handshake.
module res_station_array #(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 3,
    parameter int DATA_W  = 32,
    parameter int NUM_CDB = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         flush_i,
    input  logic                         load_i,
    input  logic [2:0]                   op_i,
    input  logic [2:0]                   funct3_i,
    input  logic                         funct7_i,
    input  logic [TAG_W-1:0]             src1_tag_i,
    input  logic [TAG_W-1:0]             src2_tag_i,
    input  logic [DATA_W-1:0]            src1_data_i,
    input  logic [DATA_W-1:0]            src2_data_i,
    input  logic                         src1_valid_i,
    input  logic                         src2_valid_i,
    input  logic [TAG_W-1:0]             dest_tag_i,
    input  logic [NUM_CDB-1:0]           cdb_valid_i,
    input  logic [NUM_CDB*TAG_W-1:0]     cdb_tag_i,
    input  logic [NUM_CDB*DATA_W-1:0]    cdb_data_i,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         issue_valid_o,
    input  logic                         alu_ready_i,
    output logic [2:0]                   issue_op_o,
    output logic [2:0]                   issue_funct3_o,
    output logic                         issue_funct7_o,
    output logic [DATA_W-1:0]            issue_src1_o,
    output logic [DATA_W-1:0]            issue_src2_o,
    output logic [TAG_W-1:0]             issue_tag_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    typedef struct packed {
        logic [2:0]        op;
        logic [2:0]        funct3;
        logic              funct7;
        logic [TAG_W-1:0]  s1_tag;
        logic [DATA_W-1:0] s1_data;
        logic              s1_val;
        logic [TAG_W-1:0]  s2_tag;
        logic [DATA_W-1:0] s2_data;
        logic              s2_val;
        logic [TAG_W-1:0]  dest;
    } entry_t;

    entry_t           slots   [DEPTH];
    entry_t           snooped [DEPTH];
    entry_t           slots_n [DEPTH];
    entry_t           new_entry;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_n;
    logic [CNT_W-1:0] wr_idx;
    logic [IDX_W-1:0] sel;
    logic             any_ready;
    logic             fire;
    logic             alloc;

    // Returns {valid, data} for one source after checking the CDB; an already
    // valid source is left alone, and the lowest matching port wins.
    function automatic logic [DATA_W:0] snoop(
        input logic                      v,
        input logic [TAG_W-1:0]          t,
        input logic [DATA_W-1:0]         d,
        input logic [NUM_CDB-1:0]        cv,
        input logic [NUM_CDB*TAG_W-1:0]  ct,
        input logic [NUM_CDB*DATA_W-1:0] cd
    );
        logic [DATA_W:0] r;
        r = {v, d};
        for (int unsigned p = 0; p < NUM_CDB; p++) begin
            if (!r[DATA_W] && cv[p] && (ct[p*TAG_W +: TAG_W] == t))
                r = {1'b1, cd[p*DATA_W +: DATA_W]};
        end
        return r;
    endfunction

    // Wake waiting operands of stored entries and of the incoming op (bypass)
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            snooped[i] = slots[i];
            {snooped[i].s1_val, snooped[i].s1_data} = snoop(slots[i].s1_val, slots[i].s1_tag,
                slots[i].s1_data, cdb_valid_i, cdb_tag_i, cdb_data_i);
            {snooped[i].s2_val, snooped[i].s2_data} = snoop(slots[i].s2_val, slots[i].s2_tag,
                slots[i].s2_data, cdb_valid_i, cdb_tag_i, cdb_data_i);
        end
        new_entry.op     = op_i;
        new_entry.funct3 = funct3_i;
        new_entry.funct7 = funct7_i;
        new_entry.s1_tag = src1_tag_i;
        new_entry.s2_tag = src2_tag_i;
        new_entry.dest   = dest_tag_i;
        {new_entry.s1_val, new_entry.s1_data} = snoop(src1_valid_i, src1_tag_i, src1_data_i,
            cdb_valid_i, cdb_tag_i, cdb_data_i);
        {new_entry.s2_val, new_entry.s2_data} = snoop(src2_valid_i, src2_tag_i, src2_data_i,
            cdb_valid_i, cdb_tag_i, cdb_data_i);
    end

    // Pick the lowest-index (oldest) occupied slot whose operands are both valid
    always_comb begin
        any_ready = 1'b0;
        sel       = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!any_ready && (32'(count_q) > i) && slots[i].s1_val && slots[i].s2_val) begin
                any_ready = 1'b1;
                sel       = IDX_W'(i);
            end
        end
    end

    // Present the selected entry; all fields read zero when nothing is ready
    always_comb begin
        issue_valid_o  = any_ready;
        issue_op_o     = '0;
        issue_funct3_o = '0;
        issue_funct7_o = 1'b0;
        issue_src1_o   = '0;
        issue_src2_o   = '0;
        issue_tag_o    = '0;
        if (any_ready) begin
            issue_op_o     = slots[sel].op;
            issue_funct3_o = slots[sel].funct3;
            issue_funct7_o = slots[sel].funct7;
            issue_src1_o   = slots[sel].s1_data;
            issue_src2_o   = slots[sel].s2_data;
            issue_tag_o    = slots[sel].dest;
        end
    end

    assign count_o = count_q;
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign fire    = any_ready & alu_ready_i;
    assign alloc   = load_i & ~full_o & ~flush_i;
    assign wr_idx  = count_q - CNT_W'(fire);

    // Next state: remove the fired slot by shifting younger slots down (taking
    // their snooped values), then append the new op after the last survivor
    always_comb begin
        count_n = flush_i ? '0 : (count_q - CNT_W'(fire) + CNT_W'(alloc));
        for (int unsigned i = 0; i < DEPTH; i++) begin
            int unsigned src;
            src = i;
            if (fire && (i >= 32'(sel)))
                src = i + 1;
            slots_n[i] = (src < DEPTH) ? snooped[src] : '0;
            if (alloc && (32'(wr_idx) == i))
                slots_n[i] = new_entry;
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++)
                slots[i] <= '0;
        end else begin
            count_q <= count_n;
            for (int unsigned i = 0; i < DEPTH; i++)
                slots[i] <= slots_n[i];
        end
    end

endmodule

// File: tb/tb_res_station_array.sv
// Self-checking bench for res_station_array: expected issues are queued when
// ops are loaded and compared in order whenever the ALU accepts an op.
module tb_res_station_array;

    localparam int DEPTH   = 4;
    localparam int TAG_W   = 3;
    localparam int DATA_W  = 32;
    localparam int NUM_CDB = 4;

    logic                        clk = 1'b0;
    logic                        reset_n;
    logic                        flush_i;
    logic                        load_i;
    logic [2:0]                  op_i;
    logic [2:0]                  funct3_i;
    logic                        funct7_i;
    logic [TAG_W-1:0]            src1_tag_i, src2_tag_i;
    logic [DATA_W-1:0]           src1_data_i, src2_data_i;
    logic                        src1_valid_i, src2_valid_i;
    logic [TAG_W-1:0]            dest_tag_i;
    logic [NUM_CDB-1:0]          cdb_valid_i;
    logic [NUM_CDB*TAG_W-1:0]    cdb_tag_i;
    logic [NUM_CDB*DATA_W-1:0]   cdb_data_i;
    logic                        full_o, empty_o;
    logic [$clog2(DEPTH+1)-1:0]  count_o;
    logic                        issue_valid_o;
    logic                        alu_ready_i;
    logic [2:0]                  issue_op_o, issue_funct3_o;
    logic                        issue_funct7_o;
    logic [DATA_W-1:0]           issue_src1_o, issue_src2_o;
    logic [TAG_W-1:0]            issue_tag_o;

    int checks = 0;
    int errors = 0;
    logic [73:0] sb_q[$];

    res_station_array #(
        .DEPTH   (DEPTH),
        .TAG_W   (TAG_W),
        .DATA_W  (DATA_W),
        .NUM_CDB (NUM_CDB)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .flush_i        (flush_i),
        .load_i         (load_i),
        .op_i           (op_i),
        .funct3_i       (funct3_i),
        .funct7_i       (funct7_i),
        .src1_tag_i     (src1_tag_i),
        .src2_tag_i     (src2_tag_i),
        .src1_data_i    (src1_data_i),
        .src2_data_i    (src2_data_i),
        .src1_valid_i   (src1_valid_i),
        .src2_valid_i   (src2_valid_i),
        .dest_tag_i     (dest_tag_i),
        .cdb_valid_i    (cdb_valid_i),
        .cdb_tag_i      (cdb_tag_i),
        .cdb_data_i     (cdb_data_i),
        .full_o         (full_o),
        .empty_o        (empty_o),
        .count_o        (count_o),
        .issue_valid_o  (issue_valid_o),
        .alu_ready_i    (alu_ready_i),
        .issue_op_o     (issue_op_o),
        .issue_funct3_o (issue_funct3_o),
        .issue_funct7_o (issue_funct7_o),
        .issue_src1_o   (issue_src1_o),
        .issue_src2_o   (issue_src2_o),
        .issue_tag_o    (issue_tag_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Issue record layout: {tag, op, funct3, funct7, src1, src2}; loads use
    // funct3 = dest and funct7 = dest[0]
    function automatic logic [73:0] exp_issue(input logic [2:0] dest, input logic [2:0] op,
                                              input logic [31:0] s1, input logic [31:0] s2);
        return {dest, op, dest, dest[0], s1, s2};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        load_i       = 1'b0;
        flush_i      = 1'b0;
        op_i         = '0;
        funct3_i     = '0;
        funct7_i     = 1'b0;
        src1_tag_i   = '0;
        src2_tag_i   = '0;
        src1_data_i  = '0;
        src2_data_i  = '0;
        src1_valid_i = 1'b0;
        src2_valid_i = 1'b0;
        dest_tag_i   = '0;
        cdb_valid_i  = '0;
        cdb_tag_i    = '0;
        cdb_data_i   = '0;
    endtask

    task automatic set_load(input logic [2:0] dest, input logic [2:0] op,
                            input logic v1, input logic [2:0] t1, input logic [31:0] d1,
                            input logic v2, input logic [2:0] t2, input logic [31:0] d2);
        load_i       = 1'b1;
        dest_tag_i   = dest;
        op_i         = op;
        funct3_i     = dest;
        funct7_i     = dest[0];
        src1_valid_i = v1;
        src1_tag_i   = t1;
        src1_data_i  = d1;
        src2_valid_i = v2;
        src2_tag_i   = t2;
        src2_data_i  = d2;
    endtask

    task automatic set_cdb(input int p, input logic [2:0] tag, input logic [31:0] data);
        cdb_valid_i[p]                 = 1'b1;
        cdb_tag_i[p*TAG_W +: TAG_W]    = tag;
        cdb_data_i[p*DATA_W +: DATA_W] = data;
    endtask

    // Scoreboard: every accepted issue must match the next queued expectation
    always @(negedge clk) begin
        logic [73:0] got;
        if (reset_n && !flush_i && issue_valid_o && alu_ready_i) begin
            got = {issue_tag_o, issue_op_o, issue_funct3_o, issue_funct7_o, issue_src1_o, issue_src2_o};
            if (sb_q.size() == 0)
                check("unexpected_issue", {1'b1, got}, '0);
            else
                check("issue_fields", got, sb_q.pop_front());
        end
    end

    initial begin
        clr_inputs();
        alu_ready_i = 1'b0;
        reset_n     = 1'b0;
        step();
        check("rst_count", count_o, 0);
        check("rst_empty", empty_o, 1);
        check("rst_full", full_o, 0);
        check("rst_issue_valid", issue_valid_o, 0);
        check("rst_issue_fields", {issue_tag_o, issue_op_o, issue_src1_o, issue_src2_o}, 0);
        reset_n = 1'b1;
        step();

        // Back-to-back ready ops
        alu_ready_i = 1'b1;
        set_load(3'd1, 3'd1, 1'b1, 3'd0, 32'd5, 1'b1, 3'd0, 32'd3);
        sb_q.push_back(exp_issue(3'd1, 3'd1, 32'd5, 32'd3));
        step();
        check("b2b_a_valid", issue_valid_o, 1);
        check("b2b_a_tag", issue_tag_o, 1);
        check("b2b_count1", count_o, 1);
        set_load(3'd2, 3'd2, 1'b1, 3'd0, 32'd9, 1'b1, 3'd0, 32'd4);
        sb_q.push_back(exp_issue(3'd2, 3'd2, 32'd9, 32'd4));
        step();
        clr_inputs();
        check("b2b_b_tag", issue_tag_o, 2);
        check("b2b_count_b", count_o, 1);
        step();
        check("b2b_count0", count_o, 0);
        check("b2b_empty", empty_o, 1);

        // Wake-up through CDB port 2, with port 3 also matching (lower port wins)
        set_load(3'd4, 3'd3, 1'b0, 3'd5, 32'd0, 1'b1, 3'd0, 32'd7);
        sb_q.push_back(exp_issue(3'd4, 3'd3, 32'h1234, 32'd7));
        step();
        clr_inputs();
        check("wake_waiting", issue_valid_o, 0);
        step();
        set_cdb(2, 3'd5, 32'h1234);
        set_cdb(3, 3'd5, 32'hDEAD);
        step();
        clr_inputs();
        check("wake_valid", issue_valid_o, 1);
        check("wake_src1", issue_src1_o, 32'h1234);
        step();
        check("wake_empty", empty_o, 1);

        // Same-cycle bypass on load
        set_load(3'd5, 3'd4, 1'b1, 3'd0, 32'h11, 1'b0, 3'd3, 32'd0);
        set_cdb(0, 3'd3, 32'hAA);
        sb_q.push_back(exp_issue(3'd5, 3'd4, 32'h11, 32'hAA));
        step();
        clr_inputs();
        check("bypass_valid", issue_valid_o, 1);
        check("bypass_src2", issue_src2_o, 32'hAA);
        step();
        check("bypass_empty", empty_o, 1);

        // Fill, overflow attempt, out-of-order issue
        set_load(3'd0, 3'd5, 1'b0, 3'd6, 32'd0, 1'b1, 3'd0, 32'h200);
        step();
        for (int i = 1; i < 4; i++) begin
            set_load(3'(i), 3'd6, 1'b1, 3'd0, 32'h100 + 32'(i), 1'b0, 3'd7, 32'd0);
            sb_q.push_back(exp_issue(3'(i), 3'd6, 32'h100 + 32'(i), 32'h77));
            step();
        end
        sb_q.push_back(exp_issue(3'd0, 3'd5, 32'h66, 32'h200));
        check("full_set", full_o, 1);
        check("full_count", count_o, 4);
        set_load(3'd5, 3'd7, 1'b1, 3'd0, 32'd1, 1'b1, 3'd0, 32'd2);
        step();
        clr_inputs();
        check("overflow_dropped", count_o, 4);
        check("none_ready", issue_valid_o, 0);
        set_cdb(1, 3'd7, 32'h77);
        step();
        clr_inputs();
        check("ooo_first", issue_tag_o, 1);
        check("ooo_full_before", full_o, 1);
        step();
        check("ooo_second", issue_tag_o, 2);
        check("ooo_count3", count_o, 3);
        check("ooo_full_drop", full_o, 0);
        step();
        check("ooo_third", issue_tag_o, 3);
        step();
        check("ooo_oldest_wait", issue_valid_o, 0);
        check("ooo_count1", count_o, 1);
        set_cdb(0, 3'd6, 32'h66);
        step();
        clr_inputs();
        check("ooo_oldest", issue_tag_o, 0);
        step();
        check("ooo_empty", empty_o, 1);

        // Stall with ALU not ready
        alu_ready_i = 1'b0;
        set_load(3'd6, 3'd2, 1'b1, 3'd0, 32'hA, 1'b1, 3'd0, 32'hB);
        sb_q.push_back(exp_issue(3'd6, 3'd2, 32'hA, 32'hB));
        step();
        clr_inputs();
        for (int i = 0; i < 3; i++) begin
            check("stall_fields", {issue_valid_o, issue_tag_o, issue_src1_o, issue_src2_o},
                  {1'b1, 3'd6, 32'hA, 32'hB});
            check("stall_count", count_o, 1);
            step();
        end
        alu_ready_i = 1'b1;
        step();
        check("stall_removed", empty_o, 1);

        // Flush with a simultaneous load
        alu_ready_i = 1'b0;
        for (int i = 1; i < 4; i++) begin
            set_load(3'(i), 3'd1, 1'b1, 3'd0, 32'd1, 1'b1, 3'd0, 32'd1);
            step();
        end
        clr_inputs();
        check("flush_pre_count", count_o, 3);
        flush_i = 1'b1;
        set_load(3'd7, 3'd1, 1'b1, 3'd0, 32'd1, 1'b1, 3'd0, 32'd1);
        #1;
        check("flush_cycle_issue", {issue_valid_o, issue_tag_o}, {1'b1, 3'd1});
        step();
        clr_inputs();
        check("flush_count", count_o, 0);
        check("flush_issue", issue_valid_o, 0);
        alu_ready_i = 1'b1;
        step();
        check("flush_load_dropped", empty_o, 1);

        // Asynchronous reset in the middle of a cycle
        alu_ready_i = 1'b0;
        for (int i = 1; i < 4; i++) begin
            set_load(3'(i), 3'd1, 1'b1, 3'd0, 32'd2, 1'b1, 3'd0, 32'd2);
            step();
        end
        clr_inputs();
        check("rst_pre_count", count_o, 3);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_async_count", count_o, 0);
        check("rst_async_flags", {empty_o, full_o, issue_valid_o}, 3'b100);
        check("rst_async_fields", {issue_tag_o, issue_src1_o, issue_src2_o}, 0);
        step();
        reset_n = 1'b1;
        step();
        check("rst_release_empty", empty_o, 1);

        check("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
